// File: rtl/demux_4_tdm.sv
// rtl/demux_4_tdm.sv - 4-way TDM serial-to-parallel demultiplexer with frame tracking
//
// Receives one serial bit per slot and rebuilds 4-bit frames.
// Optional feature macro: DEMUX_4_TDM_PARITY_EN (adds a 5th even-parity slot).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   Y            serial data bit for the current slot
//   in_valid     Y is accepted on edges where this is high
//   frame_start  accepted bit is slot 0 (ignored when in_valid is low)
//   A, B         slot index {A,B} of the next accepted bit
//   D0..D3       last completed frame (D0 = slot 0)
//   frame_valid  one-cycle pulse when D0..D3 update
//   sync_err     one-cycle pulse on a framing (or parity) error
//   busy         high while a frame is being collected

module demux_4_tdm (
    input  logic clk,
    input  logic rst,
    input  logic Y,
    input  logic in_valid,
    input  logic frame_start,
    output logic A,
    output logic B,
    output logic D0,
    output logic D1,
    output logic D2,
    output logic D3,
    output logic frame_valid,
    output logic sync_err,
    output logic busy
);

`ifdef DEMUX_4_TDM_PARITY_EN
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_SLOT = 3'd4;
`else
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] LAST_SLOT = 2'd3;
`endif

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] slot, slot_n;
    logic [3:0]       shadow, shadow_n;
    logic [3:0]       data, data_n;
    logic             frame_valid_n;
    logic             sync_err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= '0;
            shadow      <= '0;
            data        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            slot        <= slot_n;
            shadow      <= shadow_n;
            data        <= data_n;
            frame_valid <= frame_valid_n;
            sync_err    <= sync_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        slot_n        = slot;
        shadow_n      = shadow;
        data_n        = data;
        frame_valid_n = 1'b0;
        sync_err_n    = 1'b0;

        if (in_valid) begin
            if (frame_start) begin
                // A frame_start always restarts the frame; mid-frame it also
                // flags the loss of the partial frame.
                if (state == COLLECT) begin
                    sync_err_n = 1'b1;
                end
                shadow_n    = 4'b0000;
                shadow_n[0] = Y;
                slot_n      = 1;
                state_n     = COLLECT;
            end else if (state == COLLECT) begin
                if (slot == LAST_SLOT) begin
`ifdef DEMUX_4_TDM_PARITY_EN
                    // Parity slot: even parity over the four data bits.
                    if ((^shadow) == Y) begin
                        data_n        = shadow;
                        frame_valid_n = 1'b1;
                    end else begin
                        sync_err_n    = 1'b1;
                    end
`else
                    shadow_n[3]   = Y;
                    data_n        = shadow_n;
                    frame_valid_n = 1'b1;
`endif
                    slot_n  = '0;
                    state_n = IDLE;
                end else begin
                    shadow_n[slot[1:0]] = Y;
                    slot_n              = slot + 1'b1;
                end
            end
            // IDLE without frame_start: bit is discarded silently.
        end
    end

    assign A    = slot[1];
    assign B    = slot[0];
    assign D0   = data[0];
    assign D1   = data[1];
    assign D2   = data[2];
    assign D3   = data[3];
    assign busy = (state == COLLECT);

endmodule

// File: tb/tb_demux_4_tdm.sv
// tb/tb_demux_4_tdm.sv - self-checking bench for demux_4_tdm against a frame-level reference model

`timescale 1ns/1ps

module tb_demux_4_tdm;

`ifdef DEMUX_4_TDM_PARITY_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic clk = 1'b0;
    logic rst, Y, in_valid, frame_start;
    logic A, B, D0, D1, D2, D3, frame_valid, sync_err, busy;

    int checks = 0;
    int failures = 0;

    // Reference model: the list of bits collected for the frame in progress.
    int         mbits[$];
    bit         mcoll;
    logic [3:0] exp_d;
    logic       exp_fv, exp_se;
    int         fv_count, se_count;

    demux_4_tdm dut (
        .clk(clk), .rst(rst), .Y(Y), .in_valid(in_valid), .frame_start(frame_start),
        .A(A), .B(B), .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .frame_valid(frame_valid), .sync_err(sync_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model(input logic r, input logic iv, input logic fs, input logic y);
        int sum;
        exp_fv = 1'b0;
        exp_se = 1'b0;
        if (r) begin
            mbits.delete();
            mcoll = 1'b0;
            exp_d = 4'b0000;
        end else if (iv) begin
            if (fs) begin
                if (mcoll) exp_se = 1'b1;
                mbits.delete();
                mbits.push_back(int'(y));
                mcoll = 1'b1;
            end else if (mcoll) begin
                mbits.push_back(int'(y));
                if (mbits.size() == FLEN) begin
                    sum = 0;
                    foreach (mbits[i]) sum += mbits[i];
                    if (FLEN == 4 || sum % 2 == 0) begin
                        for (int i = 0; i < 4; i++) exp_d[i] = mbits[i][0];
                        exp_fv = 1'b1;
                    end else begin
                        exp_se = 1'b1;
                    end
                    mbits.delete();
                    mcoll = 1'b0;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, advance one edge, compare against the model.
    task automatic step(input logic r, input logic iv, input logic fs, input logic y);
        int ab;
        rst = r; in_valid = iv; frame_start = fs; Y = y;
        @(posedge clk);
        model(r, iv, fs, y);
        #1;
        ab = mcoll ? (mbits.size() % 4) : 0;
        if (frame_valid === 1'b1) fv_count++;
        if (sync_err === 1'b1) se_count++;
        check("ab",    {6'b0, A, B},                     8'(ab));
        check("data",  {4'b0, D3, D2, D1, D0},           {4'b0, exp_d});
        check("flags", {5'b0, frame_valid, sync_err, busy}, {5'b0, exp_fv, exp_se, mcoll});
    endtask

    task automatic send(input logic [4:0] bits, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, (i == 0), bits[i]);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0; Y = 1'b0;
        mcoll = 1'b0; exp_d = 4'b0; exp_fv = 1'b0; exp_se = 1'b0;
        fv_count = 0; se_count = 0;

        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_outputs", {A, B, D3, D2, D1, D0, frame_valid, busy}, 8'h00);

        // Frame 1,0,1,0 (bit i = slot i), parity bit 0 if enabled.
        fv_count = 0;
        send(5'b00101, FLEN);
        check("frame1010_d", {4'b0, D3, D2, D1, D0}, 8'b0000_0101);
        check("frame1010_fv_once", 8'(fv_count), 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("fv_one_cycle", {7'b0, frame_valid}, 8'd0);

        // Gap mid-frame: slots 0,1 then 3 idle cycles, then the rest.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("gap_ab_hold", {6'b0, A, B}, 8'd2);
        for (int i = 2; i < FLEN; i++) step(1'b0, 1'b1, 1'b0, (i == 2));
        check("gap_frame_d", {4'b0, D3, D2, D1, D0}, 8'b0000_0101);

        // Resync: 1,1 then frame_start with 0,1,1,0.
        se_count = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        send(5'b00110, FLEN);
        check("resync_err_once", 8'(se_count), 8'd1);
        check("resync_d", {4'b0, D3, D2, D1, D0}, 8'b0000_0110);

        // Back-to-back frames 1,1,1,1 and 0,0,0,1 (parity 0 and 1).
        fv_count = 0;
        send(5'b01111, FLEN);
        check("b2b_first", {4'b0, D3, D2, D1, D0}, 8'b0000_1111);
        send(5'b11000, FLEN);
        check("b2b_second", {4'b0, D3, D2, D1, D0}, 8'b0000_1000);
        check("b2b_fv_count", 8'(fv_count), 8'd2);

        // Reset after slot 2, then 0,1,0,1.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        fv_count = 0; se_count = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("midreset_outputs", {A, B, D3, D2, D1, D0, frame_valid, sync_err}, 8'h00);
        send(5'b01010, FLEN);
        check("after_reset_d", {4'b0, D3, D2, D1, D0}, 8'b0000_1010);
        check("after_reset_pulses", {8'(fv_count)}, 8'd1);

`ifdef DEMUX_4_TDM_PARITY_EN
        send(5'b00101, 5);
        se_count = 0; fv_count = 0;
        send(5'b01101, 5);
        check("parity_err", 8'(se_count), 8'd1);
        check("parity_no_fv", 8'(fv_count), 8'd0);
        check("parity_d_kept", {4'b0, D3, D2, D1, D0}, 8'b0000_0101);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(63) == 0), ($urandom_range(3) != 0),
                 ($urandom_range(5) == 0), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
